// File: rtl/key_event_debounce_if.sv
// rtl/key_event_debounce_if.sv - key event valid/ready handshake carrying the signed sample xin
interface key_event_debounce_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] xin;

  modport master (
    output evt_valid,
    output xin,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  xin,
    output evt_ready
  );
endinterface

// File: rtl/key_event_debounce.sv
// rtl/key_event_debounce.sv - sync, debounce and single-entry event buffer for two active-low keys
// Optional KEY_STATS_EN builds the drop_cnt/press_cnt statistics; otherwise both read 10'd0.
module key_event_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic                  key0,
  input  logic                  key1,
  key_event_debounce_if.master  evt,
  output logic [9:0]            drop_cnt,
  output logic [9:0]            press_cnt
);

  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  logic             valid_q;
  logic [1:0]       xin_q;
  logic             accept;
  logic             load;

  assign raw = {key1, key0};

  // press[i] pulses on the edge stable[i] falls; the buffer consumes it one edge later
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      stable <= 2'b11;
      press  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    accept = valid_q & evt.evt_ready;
    load   = (|press) & (~valid_q | accept);
  end

  // key0 has priority when both presses land together; xin is held after accept
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      valid_q <= 1'b0;
      xin_q   <= 2'b01;
    end else if (load) begin
      valid_q <= 1'b1;
      xin_q   <= press[0] ? 2'b01 : 2'b11;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.xin       = xin_q;

`ifdef KEY_STATS_EN
  logic [1:0] drop_n;
  logic [9:0] drop_q;
  logic [9:0] press_q;

  always_comb begin
    drop_n = 2'd0;
    if (press == 2'b11) begin
      drop_n = load ? 2'd1 : 2'd2;
    end else if (|press) begin
      drop_n = load ? 2'd0 : 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      drop_q  <= '0;
      press_q <= '0;
    end else begin
      drop_q  <= drop_q + {8'd0, drop_n};
      press_q <= press_q + {9'd0, accept};
    end
  end

  assign drop_cnt  = drop_q;
  assign press_cnt = press_q;
`else
  assign drop_cnt  = 10'd0;
  assign press_cnt = 10'd0;
`endif

endmodule

// File: tb/tb_key_event_debounce.sv
// tb/tb_key_event_debounce.sv - randomized bench for key_event_debounce against a run-length reference model
module tb_key_event_debounce;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key0 = 1'b1;
  logic       key1 = 1'b1;
  logic [9:0] drop_cnt;
  logic [9:0] press_cnt;

  int checks = 0;
  int errors = 0;

  key_event_debounce_if evt ();

  key_event_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50  (clk),
    .rst       (rst),
    .key0      (key0),
    .key1      (key1),
    .evt       (evt),
    .drop_cnt  (drop_cnt),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Reference: each key's level is seen two edges late; a level that differs from
  // the accepted one for D consecutive edges becomes the new accepted level.
  bit h0[$];
  bit h1[$];
  int stab[2];
  int run[2];
  int pend[2];
  int m_valid = 0;
  int m_xin = 1;
  int m_drop = 0;
  int m_press = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    int acc;
    int seen[2];
    if (rst) begin
      h0 = {1'b1, 1'b1};
      h1 = {1'b1, 1'b1};
      for (int i = 0; i < 2; i++) begin
        stab[i] = 1; run[i] = 0; pend[i] = 0;
      end
      m_valid = 0; m_xin = 1; m_drop = 0; m_press = 0;
      return;
    end
    acc = m_valid & int'(evt.evt_ready);
    if (pend[0] + pend[1] > 0) begin
      if (m_valid == 0 || acc == 1) begin
        m_valid = 1;
        m_xin   = (pend[0] == 1) ? 1 : 3;
        m_drop += pend[0] & pend[1];
      end else begin
        m_drop += pend[0] + pend[1];
      end
    end else if (acc == 1) begin
      m_valid = 0;
    end
    m_press += acc;
    m_drop  %= 1024;
    m_press %= 1024;
    seen[0] = int'(h0.pop_front());
    seen[1] = int'(h1.pop_front());
    h0.push_back(key0);
    h1.push_back(key1);
    for (int i = 0; i < 2; i++) begin
      run[i]  = (seen[i] != stab[i]) ? run[i] + 1 : 0;
      pend[i] = 0;
      if (run[i] == D) begin
        stab[i] = seen[i];
        run[i]  = 0;
        pend[i] = (seen[i] == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input logic k0, input logic k1, input logic rdy, input logic r);
    key0 = k0;
    key1 = k1;
    evt.evt_ready = rdy;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("evt_valid", int'(evt.evt_valid), m_valid);
    check("xin", int'(evt.xin), m_xin);
`ifdef KEY_STATS_EN
    check("drop_cnt", int'(drop_cnt), m_drop);
    check("press_cnt", int'(press_cnt), m_press);
`else
    check("drop_cnt", int'(drop_cnt), 0);
    check("press_cnt", int'(press_cnt), 0);
`endif
  endtask

  task automatic hold(input logic k0, input logic k1, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(k0, k1, rdy, 1'b0);
  endtask

  initial begin
    evt.evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 50);

    hold(1'b0, 1'b1, 1'b1, 20);
    hold(1'b1, 1'b1, 1'b1, 20);

    hold(1'b1, 1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 1'b1, 20);

    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 2);
    hold(1'b1, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b1, 5);

    hold(1'b0, 1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 1'b1, 10);

    hold(1'b1, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 2);
    hold(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    hold(1'b0, 1'b1, 1'b1, 15);
    hold(1'b1, 1'b1, 1'b1, 15);

    for (int s = 0; s < 400; s++) begin
      int len;
      logic k0, k1;
      len = $urandom_range(1, 12);
      k0 = $urandom_range(0, 1) == 0;
      k1 = $urandom_range(0, 2) == 0;
      for (int c = 0; c < len; c++) begin
        step(k0, k1, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
    end

    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int s = 0; s < 600; s++) begin
      hold(1'b0, 1'b0, 1'b0, D + 2);
      hold(1'b1, 1'b1, 1'b0, D + 2);
    end
    for (int s = 0; s < 1100; s++) begin
      hold(1'b0, 1'b1, 1'b1, D + 2);
      hold(1'b1, 1'b1, 1'b1, D + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
